iq_demod_decimator: RTL and testbench

Downstream consumer of the phasemeter NCO. Multiplies each signed ADC sample by the NCO's registered cosine and sine outputs to form I/Q products. Integrates the products in an accumulate-and-dump decimator and emits one {Q,I} word per 2^DECIM_LOG2 accepted samples on an AXI-Stream master. Feeds the phasemeter's phase-extraction/CORDIC stage.

---
 rtl/iq_demod_decimator.sv | 73 +++++++
 tb/tb_iq_demod_decimator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/iq_demod_decimator.sv
// iq_demod_decimator: mixes ADC samples with the NCO cos/sin and decimates the I/Q products by accumulate-and-dump
module iq_demod_decimator #(
  parameter int ADC_BITS = 14,
  parameter int AMPLITUDE_BITS = 14,
  parameter int DECIM_LOG2 = 10,
  parameter int OUT_WIDTH = 32
)(
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [ADC_BITS-1:0]          s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic signed [AMPLITUDE_BITS-1:0]    SINE_WAVE,
  input  logic signed [AMPLITUDE_BITS-1:0]    COS_WAVE,
  output logic        [2*OUT_WIDTH-1:0]       m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  input  logic                                OVERRUN_CLR,
  output logic                                OVERRUN
);
  localparam int P = ADC_BITS + AMPLITUDE_BITS;
  localparam int A = P + DECIM_LOG2;
  localparam int SH = A > OUT_WIDTH ? A - OUT_WIDTH : 0;
  localparam int W = A > OUT_WIDTH ? A : OUT_WIDTH;
  logic                   accept, pv, dump, dv;
  logic signed [P-1:0]    pi, pq;
  logic signed [A-1:0]    acc_i, acc_q, sum_i, sum_q;
  logic signed [W-1:0]    ext_i, ext_q;
  logic [DECIM_LOG2-1:0]  cnt;
  logic [2*OUT_WIDTH-1:0] dump_w;
  assign accept = s_axis_tvalid && s_axis_tready;
  assign dump = pv && (cnt == '1);
  assign sum_i = acc_i + A'(pi);
  assign sum_q = acc_q + A'(pq);
  // widen first so one shift covers both the truncating and the sign-extending case
  assign ext_i = W'(sum_i) >>> SH;
  assign ext_q = W'(sum_q) >>> SH;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_axis_tready <= 1'b0;
      pv <= 1'b0;
      pi <= '0;
      pq <= '0;
      acc_i <= '0;
      acc_q <= '0;
      cnt <= '0;
      dv <= 1'b0;
      dump_w <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      pv <= accept;
      if (accept) begin
        pi <= P'(s_axis_tdata) * P'(COS_WAVE);
        pq <= P'(s_axis_tdata) * P'(SINE_WAVE);
      end
      if (pv) begin
        cnt <= cnt + DECIM_LOG2'(1);
        acc_i <= dump ? '0 : sum_i;
        acc_q <= dump ? '0 : sum_q;
      end
      dv <= dump;
      if (dump) dump_w <= {ext_q[OUT_WIDTH-1:0], ext_i[OUT_WIDTH-1:0]};
      // a fresh word always wins over the handshake and replaces any unconsumed one
      if (dv) begin
        m_axis_tdata <= dump_w;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      OVERRUN <= (dv && m_axis_tvalid && !m_axis_tready) || (OVERRUN && !OVERRUN_CLR);
    end
endmodule

// File: tb/tb_iq_demod_decimator.sv
// tb_iq_demod_decimator: directed vectors on a DECIM_LOG2=2 instance and a default instance, scoreboard-checked
module tb_iq_demod_decimator;
  logic clk = 1'b0;
  logic rst;
  logic signed [13:0] tdata, sinw, cosw;
  logic tvalid, m_ready, oclr;
  logic ready_a, valid_a, ovr_a, ready_b, valid_b, ovr_b;
  logic [63:0] data_a, data_b;
  logic [63:0] qa[$], qb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iq_demod_decimator #(.DECIM_LOG2(2)) dut_a (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(ready_a),
    .SINE_WAVE(sinw), .COS_WAVE(cosw), .m_axis_tdata(data_a), .m_axis_tvalid(valid_a),
    .m_axis_tready(m_ready), .OVERRUN_CLR(oclr), .OVERRUN(ovr_a));

  iq_demod_decimator dut_b (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(ready_b),
    .SINE_WAVE(sinw), .COS_WAVE(cosw), .m_axis_tdata(data_b), .m_axis_tvalid(valid_b),
    .m_axis_tready(m_ready), .OVERRUN_CLR(oclr), .OVERRUN(ovr_b));

  function automatic logic [63:0] pack(int q, int i);
    return {q, i};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(int n, int d, int c, int s, bit gap);
    for (int i = 0; i < n; i++) begin
      tdata = 14'(d);
      cosw = 14'(c);
      sinw = 14'(s);
      tvalid = 1'b1;
      cyc(1);
      if (gap) begin
        tvalid = 1'b0;
        cyc(1);
      end
    end
    tvalid = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && valid_a && m_ready) begin
        if (qa.size() == 0) chk("a_unexpected", data_a, 64'd0);
        else chk("a_word", data_a, qa.pop_front());
      end
      if (!rst && valid_b && m_ready) begin
        if (qb.size() == 0) chk("b_unexpected", data_b, 64'd0);
        else chk("b_word", data_b, qb.pop_front());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    tdata = '0;
    sinw = '0;
    cosw = '0;
    tvalid = 1'b0;
    m_ready = 1'b1;
    oclr = 1'b0;
    fork
      monitor();
    join_none
    cyc(3);
    chk("rst_ready_a", 64'(ready_a), 64'd0);
    chk("rst_valid_a", 64'(valid_a), 64'd0);
    chk("rst_data_a", data_a, 64'd0);
    chk("rst_ovr_a", 64'(ovr_a), 64'd0);
    chk("rst_valid_b", 64'(valid_b), 64'd0);
    chk("rst_data_b", data_b, 64'd0);
    rst = 1'b0;
    cyc(1);
    chk("ready_after_rst", 64'(ready_a), 64'd1);
    // default instance: 1024 full-scale samples, shift by 6
    qb.push_back(pack(0, 1073479696));
    for (int i = 0; i < 256; i++) qa.push_back(pack(0, 268369924));
    drive(1024, 8191, 8191, 0, 1'b0);
    cyc(5);
    // single frame with output timing
    qa.push_back(pack(0, 32764000));
    drive(4, 1000, 8191, 0, 1'b0);
    cyc(1);
    chk("lat_e5_valid", 64'(valid_a), 64'd0);
    cyc(1);
    chk("lat_e6_valid", 64'(valid_a), 64'd1);
    cyc(1);
    chk("lat_e7_valid", 64'(valid_a), 64'd0);
    // negative extremes
    qa.push_back(pack(-268402688, 268435456));
    drive(4, -8192, -8192, 8191, 1'b0);
    cyc(4);
    // gapped input
    qa.push_back(pack(0, 32764000));
    drive(4, 1000, 8191, 0, 1'b1);
    cyc(4);
    // overrun: second frame overwrites first while stalled
    m_ready = 1'b0;
    qa.push_back(pack(-400000, -32764000));
    drive(4, 1000, 8191, 0, 1'b0);
    drive(4, -1000, 8191, 100, 1'b0);
    cyc(4);
    chk("ovr_set", 64'(ovr_a), 64'd1);
    chk("ovr_valid", 64'(valid_a), 64'd1);
    chk("ovr_data", data_a, pack(-400000, -32764000));
    cyc(3);
    chk("ovr_sticky", 64'(ovr_a), 64'd1);
    oclr = 1'b1;
    cyc(1);
    oclr = 1'b0;
    chk("ovr_clr", 64'(ovr_a), 64'd0);
    m_ready = 1'b1;
    cyc(1);
    chk("ovr_one_hs", 64'(valid_a), 64'd0);
    cyc(2);
    // reset mid-frame
    drive(2, 3000, 5000, 7000, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ready_a), 64'd0);
    chk("mid_rst_data", data_a, 64'd0);
    chk("mid_rst_valid", 64'(valid_a), 64'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    qa.push_back(pack(0, 32764000));
    drive(4, 1000, 8191, 0, 1'b0);
    cyc(5);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
